// File: rtl/data_receive_if.sv
// data_receive_if: the bus between the UART receive engine and its surroundings.
//   enable     arms start-bit detection (sampled only while the receiver idles)
//   tick       one-clk pulse at SAMPLES x baud, from the shared baud generator
//   rx         asynchronous serial line, idle level 1
//   data_o     last received word, holds until the next completed frame
//   done       one-cycle strobe when data_o updates
//   frame_err  stop bit sampled 0 on the last frame
//   parity_err parity mismatch on the last frame (0 unless parity is built in)
// master: the side that drives the line and consumes words; slave: the receiver.
interface data_receive_if #(parameter int BITS = 8);
  logic            enable;
  logic            tick;
  logic            rx;
  logic [BITS-1:0] data_o;
  logic            done;
  logic            frame_err;
  logic            parity_err;

  modport master (output enable, tick, rx,
                  input  data_o, done, frame_err, parity_err);
  modport slave  (input  enable, tick, rx,
                  output data_o, done, frame_err, parity_err);
endinterface

// File: rtl/data_receive.sv
// data_receive: UART receive engine, LSB first, 1 start, BITS data, 1 stop.
// Oversamples the line with tick (SAMPLES ticks per bit) and samples each
// bit at its middle. Reports each word with a one-cycle done strobe.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  data_receive_if.slave (enable, tick, rx in; data_o, done,
//        frame_err, parity_err out)
// Build option: define DATA_RECEIVE_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit; otherwise parity_err is tied to 0.
module data_receive #(
  parameter int BITS    = 8,
  parameter int SAMPLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  data_receive_if.slave bus
);
  localparam int SW = $clog2(SAMPLES);
  localparam logic [SW-1:0] S_MID  = SW'(SAMPLES/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLES - 1);
  localparam logic [2:0]    N_LAST = 3'(BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [BITS-1:0] sh_q, sh_d;
  logic [BITS-1:0] data_q, data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
`ifdef DATA_RECEIVE_PARITY_EN
  logic            pbit_q, pbit_d;
  logic            perr_q, perr_d;
`endif

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef DATA_RECEIVE_PARITY_EN
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], bus.rx};
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef DATA_RECEIVE_PARITY_EN
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef DATA_RECEIVE_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        // Start detection is edge-level, not tick-qualified.
        if (bus.enable && !rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (bus.tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;  // glitch shorter than half a bit
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.tick) begin
          if (s_q == S_LAST) begin
            s_d  = '0;
            sh_d = {rx_s, sh_q[BITS-1:1]};  // LSB arrives first
            if (n_q == N_LAST) begin
`ifdef DATA_RECEIVE_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef DATA_RECEIVE_PARITY_EN
      PARITY: begin
        if (bus.tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            pbit_d  = rx_s;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            data_d  = sh_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef DATA_RECEIVE_PARITY_EN
            // Even parity: the parity bit equals the XOR of the data bits.
            perr_d  = pbit_q ^ (^sh_q);
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_o    = data_q;
  assign bus.done      = done_q;
  assign bus.frame_err = ferr_q;
`ifdef DATA_RECEIVE_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_receive.sv
// Bench for data_receive: 8N1 frames at 64 clk per bit (tick every 4 clk).
// Each frame that should complete pushes its expected word into exp_q; the
// monitor pops and compares on every done pulse.
module tb_data_receive;
  localparam int BITS = 8;
  localparam int SAMPLES = 16;
  localparam int BIT_CLK = 64;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  data_receive_if #(.BITS(BITS)) bus ();

  data_receive #(.BITS(BITS), .SAMPLES(SAMPLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int cyc = 0;
  logic prev_done = 1'b0;
  exp_t exp_q[$];
  int done_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tick: one clk high out of every four, changed on falling edges.
  initial begin
    bus.tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      done_cnt++;
      done_t.push_back(cyc);
      if (prev_done) chk("done_width", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {24'h0, bus.data_o}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_o", {24'h0, bus.data_o}, {24'h0, e.data});
        chk("frame_err", {31'h0, bus.frame_err}, {31'h0, e.ferr});
        chk("parity_err", {31'h0, bus.parity_err}, {31'h0, e.perr});
      end
    end
    prev_done = rst && bus.done;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d; e.ferr = fe; e.perr = pe;
    exp_q.push_back(e);
    exp_done++;
  endtask

  // stop_len lets a forced-0 stop bit end early so the line is clearly idle
  // before any re-detected start bit reaches its mid-point.
  task automatic send(input logic [7:0] d, input logic stop, input logic par, input int stop_len);
    bus.rx = 1'b0; wait_clk(BIT_CLK);
    for (int i = 0; i < BITS; i++) begin
      bus.rx = d[i]; wait_clk(BIT_CLK);
    end
`ifdef DATA_RECEIVE_PARITY_EN
    bus.rx = par; wait_clk(BIT_CLK);
`else
    if (par) begin end
`endif
    bus.rx = stop; wait_clk(stop_len);
    bus.rx = 1'b1;
  endtask

  initial begin
    rst = 1'b0; bus.enable = 1'b0; bus.rx = 1'b1;
    wait_clk(5);
    chk("rst_data_o", {24'h0, bus.data_o}, 0);
    chk("rst_done", {31'h0, bus.done}, 0);
    chk("rst_frame_err", {31'h0, bus.frame_err}, 0);
    chk("rst_parity_err", {31'h0, bus.parity_err}, 0);
    rst = 1'b1;
    wait_clk(5);
    bus.enable = 1'b1;

    // Plain frame.
    expect_word(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0, BIT_CLK);
    wait_clk(BIT_CLK);
    chk("a5_done_cnt", done_cnt, exp_done);

    // Start glitch of two ticks.
    bus.rx = 1'b0; wait_clk(8); bus.rx = 1'b1;
    wait_clk(2*BIT_CLK);
    chk("glitch_done_cnt", done_cnt, exp_done);
    chk("glitch_data_o", {24'h0, bus.data_o}, 32'hA5);

    // Framing error, then recovery.
    expect_word(8'h3C, 1'b1, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 40);
    wait_clk(2*BIT_CLK);
    chk("ferr_done_cnt", done_cnt, exp_done);
    expect_word(8'h81, 1'b0, 1'b0);
    send(8'h81, 1'b1, 1'b0, BIT_CLK);
    wait_clk(BIT_CLK);
    chk("81_done_cnt", done_cnt, exp_done);

    // Back-to-back frames, no idle gap.
    expect_word(8'h00, 1'b0, 1'b0);
    expect_word(8'hFF, 1'b0, 1'b1 & 1'b0);
    send(8'h00, 1'b1, 1'b0, BIT_CLK);
    send(8'hFF, 1'b1, 1'b0, BIT_CLK);
    wait_clk(BIT_CLK);
    chk("b2b_done_cnt", done_cnt, exp_done);
    if (done_t.size() >= 2)
      chk("b2b_spacing", done_t[done_t.size()-1] - done_t[done_t.size()-2], 10*BIT_CLK);
    else
      chk("b2b_spacing", 0, 10*BIT_CLK);

    // Receiver disarmed for a whole frame.
    bus.enable = 1'b0;
    send(8'h55, 1'b1, 1'b0, BIT_CLK);
    wait_clk(BIT_CLK);
    chk("disabled_done_cnt", done_cnt, exp_done);
    bus.enable = 1'b1;
    expect_word(8'h55, 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b0, BIT_CLK);
    wait_clk(BIT_CLK);
    chk("55_done_cnt", done_cnt, exp_done);

    // Reset pulse in the middle of the data bits.
    bus.rx = 1'b0; wait_clk(BIT_CLK);
    bus.rx = 1'b0; wait_clk(BIT_CLK);
    bus.rx = 1'b1; wait_clk(BIT_CLK);
    bus.rx = 1'b0; wait_clk(BIT_CLK/2);
    rst = 1'b0; bus.rx = 1'b1;
    #1;
    chk("midrst_data_o", {24'h0, bus.data_o}, 0);
    chk("midrst_done", {31'h0, bus.done}, 0);
    chk("midrst_frame_err", {31'h0, bus.frame_err}, 0);
    chk("midrst_parity_err", {31'h0, bus.parity_err}, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(12*BIT_CLK);
    chk("midrst_done_cnt", done_cnt, exp_done);
    expect_word(8'h12, 1'b0, 1'b0);
    send(8'h12, 1'b1, 1'b0, BIT_CLK);
    wait_clk(BIT_CLK);
    chk("12_done_cnt", done_cnt, exp_done);

`ifdef DATA_RECEIVE_PARITY_EN
    expect_word(8'h07, 1'b0, 1'b0);
    send(8'h07, 1'b1, 1'b1, BIT_CLK);
    wait_clk(BIT_CLK);
    expect_word(8'h07, 1'b0, 1'b1);
    send(8'h07, 1'b1, 1'b0, BIT_CLK);
    wait_clk(BIT_CLK);
    chk("par_done_cnt", done_cnt, exp_done);
`endif

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_receive.md
Name: data_receive

Overview:
- UART receive engine; the counterpart of the team's 8N1 transmit engine. Same serial line format: LSB first, one start bit, BITS data bits, one stop bit.
- Recovers bytes from the asynchronous rx line using an oversampling tick from the shared baud generator.
- Presents each received word with a one-cycle done strobe and a framing-error flag to the downstream consumer.

Parameters:
- BITS, 8, data bits per frame (valid range 5..8).
- SAMPLES, 16, tick pulses per bit period (power of two, 8 or 16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- enable  input  1  arms start-bit detection; sampled only in IDLE.
- tick  input  1  one-clk pulse at SAMPLES x baud rate.
- rx  input  1  asynchronous serial line; idle level 1.
- data_o  output  BITS  last received word; holds until the next completed frame.
- done  output  1  one-cycle strobe when data_o updates.
- frame_err  output  1  stop bit sampled 0 on the last frame; updated together with done.
- parity_err  output  1  parity mismatch on the last frame; see Optional Feature.

Behaviour:
- rx passes through a 2-flop synchronizer whose flops reset to 1. All decisions use the synchronized value rx_s.
- Reset values: data_o=0, done=0, frame_err=0, parity_err=0, state=IDLE, sample counter s=0, bit counter n=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No done is produced for that frame.
- Sample counter s is log2(SAMPLES) bits wide. Bit counter n is 3 bits wide. s and n advance only in cycles where tick=1.
- IDLE: if enable=1 and rx_s=0, go to START with s=0. Otherwise stay in IDLE.
- START: on each tick, if s==SAMPLES/2-1 (mid start bit):
  - rx_s=0: go to DATA with s=0, n=0.
  - rx_s=1: false start; return to IDLE with no outputs changed.
  - Otherwise s++.
- DATA: on each tick, if s==SAMPLES-1, then s=0 and the shift register shifts right with rx_s into the MSB.
  - If n==BITS-1, go to STOP (or PARITY when the feature is enabled).
  - Otherwise n++.
  - Otherwise s++.
- STOP: on the tick with s==SAMPLES-1, in the same clk edge:
  - data_o <= shift register.
  - frame_err <= ~rx_s.
  - done <= 1.
  - state <= IDLE.
- done drops to 0 on the next clk.
- Latency: done is high in the clk cycle after the mid-stop-bit tick.
- A stop bit of 0 still completes the frame (done=1, frame_err=1). The receiver returns to IDLE and may re-detect a start bit if rx_s is still 0 and enable=1.
- enable deasserted mid-frame does not abort; the current frame completes.
- Back-to-back frames: IDLE accepts a new start edge in the cycle immediately after done.
- Samples are taken only when tick=1. The tick phase relative to the rx edge gives at most 1/SAMPLES bit of sampling skew.

Optional Feature:
- Macro: DATA_RECEIVE_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, with the same mid-bit sampling rule (s==SAMPLES-1).
  - Expected bit is even parity: XOR of the data bits.
  - parity_err <= (sampled bit != expected), updated on the same edge as done.
  - Frame length is BITS+3 bit periods.
- Undefined:
  - No PARITY state.
  - parity_err is tied to 0.
  - Frame length is BITS+2 bit periods.

Test Plan:
- tick every 4 clk (64 clk per bit); send 0xA5 with a valid stop bit -> exactly one done pulse, data_o=0xA5, frame_err=0, rx idle afterwards.
- rx low for 2 ticks only (glitch shorter than half a bit), then high -> FSM returns to IDLE, done never asserts, data_o unchanged.
- send 0x3C with stop bit forced 0 -> done=1, data_o=0x3C, frame_err=1; then send 0x81 with a valid stop bit -> done, data_o=0x81, frame_err=0.
- back-to-back frames 0x00 then 0xFF with no idle gap -> two done pulses, exactly 10 bit periods apart; data_o=0x00 then 0xFF.
- enable=0 during a 0x55 frame -> no done; enable=1 and send 0x55 -> done. Then drive rst=0 for 1 clk in mid-DATA -> all outputs 0, no done, and the next 0x12 frame is received correctly.
- DATA_RECEIVE_PARITY_EN defined: 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1, data_o=0x07.
